if_id_stage: RTL
================

Name: if_id_stage

Overview:
- IF/ID pipeline register plus ID-stage control for the 5-stage DLX pipeline.
- Captures fetched instruction and PC+4, resolves branches and jumps in ID, and returns leap/leap_addr to fetch.
- Detects load-use and branch-operand hazards, then stalls fetch and holds the latch, or squashes the wrong-path instruction.
- Bit ordering is big-endian throughout: [0:31], bit 0 = MSB.

Parameters:
NOP_WORD, 32'h54000000, bubble encoding loaded on reset or squash
CNT_W, 16, width of saturating stall/flush performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_pcplus4  in  [0:31]  PC+4 from fetch
if_instr  in  [0:31]  instruction from imem
rs1_data  in  [0:31]  register-file read of rs1_addr (combinational)
ex_reg_write  in  1  EX instruction writes a register
ex_load  in  1  EX instruction is a load
ex_rd  in  [0:4]  EX destination
mem_load  in  1  MEM instruction is a load
mem_rd  in  [0:4]  MEM destination
id_instr  out  [0:31]  latched instruction
id_pcplus4  out  [0:31]  latched PC+4
id_valid  out  1  latched instruction is real (not a bubble)
rs1_addr  out  [0:4]  id_instr[6:10]
rs2_addr  out  [0:4]  id_instr[11:15]
leap  out  1  redirect fetch
leap_addr  out  [0:31]  redirect target
pc_write_en  out  1  fetch PC register write enable
bubble_out  out  1  ID/EX must load NOP this cycle
stall_count  out  [CNT_W-1:0]  stall cycles, saturating
flush_count  out  [CNT_W-1:0]  squashes, saturating

Behaviour:
- Reset (reset=0, async): id_instr=NOP_WORD, id_pcplus4=0, id_valid=0, both counters=0. Combinational outputs follow: leap=0, pc_write_en=1, bubble_out=0.
- Decode fields: op=id_instr[0:5], imm16=[16:31], off26=[6:31].
- Opcodes: J=02, JAL=03, BEQZ=04, BNEZ=05, JR=12, JALR=13, LW-class loads=20–27, stores=28–2F (hex).
- uses_rs1: all ops except J, JAL, NOP.
- uses_rs2: op=00 (R-type) or stores.
- is_ctl: BEQZ, BNEZ, JR, JALR.
- Hazards; all gated by id_valid, and rd=0 never hazards:
  - load_use = ex_load & ((uses_rs1 & ex_rd==rs1_addr) | (uses_rs2 & ex_rd==rs2_addr)).
  - ctl_haz = is_ctl & ((ex_reg_write & ex_rd==rs1_addr) | (mem_load & mem_rd==rs1_addr)).
  - stall = load_use | ctl_haz.
- Redirect (combinational; only when id_valid & !stall):
  - J/JAL: leap=1, leap_addr = id_pcplus4 + sext(off26).
  - BEQZ: taken iff rs1_data==0. BNEZ: taken iff rs1_data!=0. Taken: leap_addr = id_pcplus4 + sext(imm16).
  - JR/JALR: leap=1, leap_addr = rs1_data.
  - Otherwise leap=0, leap_addr=0.
  - All additions are 32-bit modulo 2^32; wrap-around is silent.
- pc_write_en = !stall. bubble_out = stall.
- Latch update on posedge clk, priority order:
  1. stall: hold id_instr, id_pcplus4, id_valid; stall_count +1.
  2. leap: id_instr=NOP_WORD, id_valid=0, id_pcplus4=if_pcplus4; flush_count +1. The wrong-path instruction is squashed; there is no delay slot.
  3. else: id_instr=if_instr, id_pcplus4=if_pcplus4, id_valid=1.
- Stall and leap are never simultaneously asserted; stall suppresses leap until the hazard clears, then the branch re-evaluates.
- Counters saturate at all-ones and do not wrap.
- Reset mid-stall or mid-redirect: the latch immediately returns to reset values; no pending redirect survives.
- Fetch must connect pc_write_en to its PC register writeEnable, replacing the constant 1.

Decomposition:
- Shared package dlx_pkg holds:
  - opcode constants (OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_JR, OP_JALR, load/store ranges);
  - NOP_WORD;
  - field-slice constants.
- One natural sub-module: id_branch_unit. It is combinational and produces leap/leap_addr from id_instr, id_pcplus4, rs1_data, id_valid and stall.
- Hazard logic, the latch and the counters stay in the top.

Test Plan:
1. Reset low with if_instr=0x20220008 applied → id_instr=0x54000000, id_valid=0, leap=0, pc_write_en=1. Release reset; the next edge latches 0x20220008 with id_valid=1.
2. Load-use: ID holds ADD r3,r1,r2 while ex_load=1, ex_rd=1 → stall=1, pc_write_en=0, bubble_out=1 for exactly 1 cycle; latch holds; stall_count=1.
3. BEQZ r4,+8 with id_pcplus4=0x100 and rs1_data=0 → leap=1, leap_addr=0x108. Next edge: id_valid=0, id_instr=NOP, flush_count=1. Repeat with rs1_data=5 → leap=0 and no flush.
4. JR r5, rs1_data=0x2000, ex_reg_write=1, ex_rd=5 → stall 1 cycle with leap=0. Next cycle (ex_reg_write=0) leap=1, leap_addr=0x2000.
5. J with off26=0x3FFFFFC and id_pcplus4=0x10 → leap_addr=0x0C (negative offset). With id_pcplus4=0xFFFFFFFC and offset +8 → leap_addr=0x4 (wrap).
6. Force 2^16+5 stalls → stall_count holds at 0xFFFF. Assert reset mid-stall → counters=0 and id_valid=0 asynchronously.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, instruction field positions, bubble word
// and small decode helpers used by the IF/ID stage and its branch unit.
// All instruction vectors are big-endian, bit 0 = MSB.
package dlx_pkg;

  localparam logic [0:31] NOP_WORD = 32'h5400_0000;
  localparam int          CNT_W    = 16;

  // Instruction field slices (big-endian bit numbers)
  localparam int OP_HI  = 0;
  localparam int OP_LO  = 5;
  localparam int RS1_HI = 6;
  localparam int RS1_LO = 10;
  localparam int RS2_HI = 11;
  localparam int RS2_LO = 15;
  localparam int IMM_HI = 16;
  localparam int IMM_LO = 31;
  localparam int OFF_HI = 6;
  localparam int OFF_LO = 31;

  typedef logic [0:5] opcode_t;

  localparam opcode_t OP_RTYPE    = 6'h00;
  localparam opcode_t OP_J        = 6'h02;
  localparam opcode_t OP_JAL      = 6'h03;
  localparam opcode_t OP_BEQZ     = 6'h04;
  localparam opcode_t OP_BNEZ     = 6'h05;
  localparam opcode_t OP_JR       = 6'h12;
  localparam opcode_t OP_JALR     = 6'h13;
  localparam opcode_t OP_NOP      = 6'h15;
  localparam opcode_t OP_LOAD_LO  = 6'h20;
  localparam opcode_t OP_LOAD_HI  = 6'h27;
  localparam opcode_t OP_STORE_LO = 6'h28;
  localparam opcode_t OP_STORE_HI = 6'h2F;

  // What the IF/ID latch does on the next clock edge
  typedef enum logic [1:0] {
    LATCH_LOAD   = 2'd0,
    LATCH_HOLD   = 2'd1,
    LATCH_SQUASH = 2'd2
  } latch_op_t;

  function automatic logic is_store(input opcode_t op);
    return (op >= OP_STORE_LO) && (op <= OP_STORE_HI);
  endfunction

  function automatic logic uses_rs1(input opcode_t op);
    return !((op == OP_J) || (op == OP_JAL) || (op == OP_NOP));
  endfunction

  function automatic logic uses_rs2(input opcode_t op);
    return (op == OP_RTYPE) || is_store(op);
  endfunction

  // Control transfers whose outcome depends on rs1 in ID
  function automatic logic is_ctl(input opcode_t op);
    return (op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_JR) || (op == OP_JALR);
  endfunction

  function automatic logic [0:31] sext16(input logic [0:15] imm);
    return {{16{imm[0]}}, imm};
  endfunction

  function automatic logic [0:31] sext26(input logic [0:25] off);
    return {{6{off[0]}}, off};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of the IF/ID stage's fetch, register-file, forwarding-status and
// ID-side signals. The stage is the slave; the surrounding pipeline is master.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);

  logic [0:31]      if_pcplus4;
  logic [0:31]      if_instr;
  logic [0:31]      rs1_data;
  logic             ex_reg_write;
  logic             ex_load;
  logic [0:4]       ex_rd;
  logic             mem_load;
  logic [0:4]       mem_rd;

  logic [0:31]      id_instr;
  logic [0:31]      id_pcplus4;
  logic             id_valid;
  logic [0:4]       rs1_addr;
  logic [0:4]       rs2_addr;
  logic             leap;
  logic [0:31]      leap_addr;
  logic             pc_write_en;
  logic             bubble_out;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_pcplus4, if_instr, rs1_data, ex_reg_write, ex_load, ex_rd,
           mem_load, mem_rd,
    input  id_instr, id_pcplus4, id_valid, rs1_addr, rs2_addr, leap,
           leap_addr, pc_write_en, bubble_out, stall_count, flush_count
  );

  modport slave (
    input  if_pcplus4, if_instr, rs1_data, ex_reg_write, ex_load, ex_rd,
           mem_load, mem_rd,
    output id_instr, id_pcplus4, id_valid, rs1_addr, rs2_addr, leap,
           leap_addr, pc_write_en, bubble_out, stall_count, flush_count
  );

endinterface

// File: rtl/id_branch_unit.sv
// ID-stage branch/jump resolution. Purely combinational: decides whether
// fetch must be redirected and computes the target. Suppressed while the
// stage is stalled so a branch only resolves on fresh operands.
module id_branch_unit
  import dlx_pkg::*;
(
  input  logic [0:31] id_instr,
  input  logic [0:31] id_pcplus4,
  input  logic [0:31] rs1_data,
  input  logic        id_valid,
  input  logic        stall,
  output logic        leap,
  output logic [0:31] leap_addr
);

  opcode_t     op_s;
  logic [0:31] br_target_s;
  logic [0:31] j_target_s;

  assign op_s        = id_instr[OP_HI:OP_LO];
  assign br_target_s = id_pcplus4 + sext16(id_instr[IMM_HI:IMM_LO]);
  assign j_target_s  = id_pcplus4 + sext26(id_instr[OFF_HI:OFF_LO]);

  // Select redirect and target from the opcode and rs1 zero test
  always_comb begin
    leap      = 1'b0;
    leap_addr = 32'h0000_0000;
    if (id_valid && !stall) begin
      case (op_s)
        OP_J, OP_JAL: begin
          leap      = 1'b1;
          leap_addr = j_target_s;
        end
        OP_BEQZ: begin
          if (rs1_data == 32'h0000_0000) begin
            leap      = 1'b1;
            leap_addr = br_target_s;
          end else begin
            leap      = 1'b0;
            leap_addr = 32'h0000_0000;
          end
        end
        OP_BNEZ: begin
          if (rs1_data != 32'h0000_0000) begin
            leap      = 1'b1;
            leap_addr = br_target_s;
          end else begin
            leap      = 1'b0;
            leap_addr = 32'h0000_0000;
          end
        end
        OP_JR, OP_JALR: begin
          leap      = 1'b1;
          leap_addr = rs1_data;
        end
        default: begin
          leap      = 1'b0;
          leap_addr = 32'h0000_0000;
        end
      endcase
    end else begin
      leap      = 1'b0;
      leap_addr = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline latch with ID-stage hazard detection, branch resolution
// and saturating stall/flush counters. A stall holds the latch and freezes
// the PC; a taken redirect squashes the wrong-path fetch into a bubble.
module if_id_stage
  import dlx_pkg::*;
#(
  parameter logic [0:31] NOP_WORD = dlx_pkg::NOP_WORD,
  parameter int          CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  if_id_stage_if.slave bus
);

  logic [0:31]      id_instr_r;
  logic [0:31]      id_pcplus4_r;
  logic             id_valid_r;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;

  opcode_t          op_s;
  logic [0:4]       rs1_addr_s;
  logic [0:4]       rs2_addr_s;
  logic             load_use_s;
  logic             ctl_haz_s;
  logic             stall_s;
  logic             leap_s;
  logic [0:31]      leap_addr_s;
  latch_op_t        latch_op_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign op_s       = id_instr_r[OP_HI:OP_LO];
  assign rs1_addr_s = id_instr_r[RS1_HI:RS1_LO];
  assign rs2_addr_s = id_instr_r[RS2_HI:RS2_LO];

  // Detect load-use and branch-operand hazards; r0 never conflicts
  always_comb begin
    load_use_s = 1'b0;
    ctl_haz_s  = 1'b0;
    if (id_valid_r) begin
      load_use_s = bus.ex_load && (bus.ex_rd != 5'd0) &&
                   ((uses_rs1(op_s) && (bus.ex_rd == rs1_addr_s)) ||
                    (uses_rs2(op_s) && (bus.ex_rd == rs2_addr_s)));
      ctl_haz_s  = is_ctl(op_s) &&
                   ((bus.ex_reg_write && (bus.ex_rd != 5'd0) && (bus.ex_rd == rs1_addr_s)) ||
                    (bus.mem_load && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs1_addr_s)));
    end else begin
      load_use_s = 1'b0;
      ctl_haz_s  = 1'b0;
    end
  end

  assign stall_s = load_use_s || ctl_haz_s;

  id_branch_unit u_branch (
    .id_instr   (id_instr_r),
    .id_pcplus4 (id_pcplus4_r),
    .rs1_data   (bus.rs1_data),
    .id_valid   (id_valid_r),
    .stall      (stall_s),
    .leap       (leap_s),
    .leap_addr  (leap_addr_s)
  );

  // Choose the latch action: stall beats redirect beats normal advance
  always_comb begin
    latch_op_s = LATCH_LOAD;
    if (stall_s) begin
      latch_op_s = LATCH_HOLD;
    end else if (leap_s) begin
      latch_op_s = LATCH_SQUASH;
    end else begin
      latch_op_s = LATCH_LOAD;
    end
  end

  // IF/ID latch: hold on stall, bubble on redirect, else capture fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_instr_r   <= NOP_WORD;
      id_pcplus4_r <= 32'h0000_0000;
      id_valid_r   <= 1'b0;
    end else begin
      case (latch_op_s)
        LATCH_HOLD: begin
          id_instr_r   <= id_instr_r;
          id_pcplus4_r <= id_pcplus4_r;
          id_valid_r   <= id_valid_r;
        end
        LATCH_SQUASH: begin
          id_instr_r   <= NOP_WORD;
          id_pcplus4_r <= bus.if_pcplus4;
          id_valid_r   <= 1'b0;
        end
        LATCH_LOAD: begin
          id_instr_r   <= bus.if_instr;
          id_pcplus4_r <= bus.if_pcplus4;
          id_valid_r   <= 1'b1;
        end
        default: begin
          id_instr_r   <= NOP_WORD;
          id_pcplus4_r <= 32'h0000_0000;
          id_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating counts of stall cycles and squashed fetches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_r <= '0;
      flush_count_r <= '0;
    end else begin
      case (latch_op_s)
        LATCH_HOLD:   stall_count_r <= sat_inc(stall_count_r);
        LATCH_SQUASH: flush_count_r <= sat_inc(flush_count_r);
        LATCH_LOAD: begin
          stall_count_r <= stall_count_r;
          flush_count_r <= flush_count_r;
        end
        default: begin
          stall_count_r <= stall_count_r;
          flush_count_r <= flush_count_r;
        end
      endcase
    end
  end

  assign bus.id_instr    = id_instr_r;
  assign bus.id_pcplus4  = id_pcplus4_r;
  assign bus.id_valid    = id_valid_r;
  assign bus.rs1_addr    = rs1_addr_s;
  assign bus.rs2_addr    = rs2_addr_s;
  assign bus.leap        = leap_s;
  assign bus.leap_addr   = leap_addr_s;
  assign bus.pc_write_en = !stall_s;
  assign bus.bubble_out  = stall_s;
  assign bus.stall_count = stall_count_r;
  assign bus.flush_count = flush_count_r;

endmodule
